// File: rtl/cic_decimator_if.sv
// I/Q sample bus for cic_decimator: full-rate input side and decimated output side.
interface cic_decimator_if #(
  parameter int BITS     = 16,
  parameter int OUT_BITS = 16
);
  logic                       in_valid;
  logic signed [BITS-1:0]     I_in;
  logic signed [BITS-1:0]     Q_in;
  logic                       out_valid;
  logic signed [OUT_BITS-1:0] I_out;
  logic signed [OUT_BITS-1:0] Q_out;

  modport master (
    output in_valid, I_in, Q_in,
    input  out_valid, I_out, Q_out
  );

  modport slave (
    input  in_valid, I_in, Q_in,
    output out_valid, I_out, Q_out
  );
endinterface

// File: rtl/cic_decimator.sv
// Dual-channel (I/Q) CIC decimator, R = 2**LOG2_DECIM, M = 1, N = STAGES.
// Define CIC_ROUND_EN for a round-half-up, saturating trim (adds one output register).

module cic_lane #(
  parameter int BITS       = 16,
  parameter int STAGES     = 3,
  parameter int LOG2_DECIM = 6,
  parameter int OUT_BITS   = 16,
  parameter int PIPE       = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                dump,
  input  logic [PIPE-1:0]     stb,
  input  logic [BITS-1:0]     x,
  output logic [OUT_BITS-1:0] y
);
  localparam int W = BITS + STAGES*LOG2_DECIM;

  logic [STAGES-1:0][W-1:0] integ;
  // cs[0] is the latched integrator sample; cs[k] is the output of comb stage k
  logic [STAGES-1:0][W-1:0] cs;
  logic [STAGES-1:0][W-1:0] dly;
  logic [W-1:0]             x_ext;
  logic [W-1:0]             diff_last;
  logic                     unused_lo;

  assign x_ext     = {{(W-BITS){x[BITS-1]}}, x};
  assign diff_last = cs[STAGES-1] - dly[STAGES-1];

  // Modulo-2**W wrap is intended: the combs recover the exact result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ <= '0;
    end else if (in_valid) begin
      integ[0] <= integ[0] + x_ext;
      for (int k = 1; k < STAGES; k++)
        integ[k] <= integ[k] + integ[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs  <= '0;
      dly <= '0;
    end else begin
      if (dump) cs[0] <= integ[STAGES-1];
      for (int k = 1; k < STAGES; k++) begin
        if (stb[k-1]) begin
          dly[k-1] <= cs[k-1];
          cs[k]    <= cs[k-1] - dly[k-1];
        end
      end
      if (stb[STAGES-1]) dly[STAGES-1] <= cs[STAGES-1];
    end
  end

`ifdef CIC_ROUND_EN
  localparam int SH = W - OUT_BITS;
  localparam logic [W:0] HALF = (SH > 0) ? ({{W{1'b0}}, 1'b1} << ((SH > 0) ? SH-1 : 0)) : '0;

  logic [W-1:0]      cs_last;
  logic [W:0]        rnd;
  logic [OUT_BITS:0] tr;

  // One guard bit above the sign so the rounding carry can be seen and saturated.
  assign rnd       = {cs_last[W-1], cs_last} + HALF;
  assign tr        = rnd[W:SH];
  assign unused_lo = ^rnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_last <= '0;
      y       <= '0;
    end else begin
      if (stb[STAGES-1]) cs_last <= diff_last;
      if (stb[STAGES]) begin
        if (tr[OUT_BITS] != tr[OUT_BITS-1])
          y <= tr[OUT_BITS] ? {1'b1, {(OUT_BITS-1){1'b0}}} : {1'b0, {(OUT_BITS-1){1'b1}}};
        else
          y <= tr[OUT_BITS-1:0];
      end
    end
  end
`else
  assign unused_lo = ^diff_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              y <= '0;
    else if (stb[STAGES-1])  y <= diff_last[W-1 -: OUT_BITS];
  end
`endif
endmodule

module cic_decimator #(
  parameter int BITS       = 16,
  parameter int STAGES     = 3,
  parameter int LOG2_DECIM = 6,
  parameter int OUT_BITS   = 16
) (
  input logic           CLK,
  input logic           RSTb,
  cic_decimator_if.slave bus
);
  localparam int NUM_LANES = 2;
`ifdef CIC_ROUND_EN
  localparam int PIPE = STAGES + 1;
`else
  localparam int PIPE = STAGES;
`endif

  logic [LOG2_DECIM-1:0]              cnt;
  logic                               dump;
  logic [PIPE:0]                      vld_pipe;
  logic [NUM_LANES-1:0][BITS-1:0]     x_l;
  logic [NUM_LANES-1:0][OUT_BITS-1:0] y_l;

  // Last accepted sample of a frame: latch integrators and launch the comb strobe.
  assign dump = bus.in_valid && (&cnt);
  assign x_l  = {bus.Q_in, bus.I_in};

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      cnt      <= '0;
      vld_pipe <= '0;
    end else begin
      if (bus.in_valid) cnt <= cnt + LOG2_DECIM'(1);
      vld_pipe <= {vld_pipe[PIPE-1:0], dump};
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    cic_lane #(
      .BITS       (BITS),
      .STAGES     (STAGES),
      .LOG2_DECIM (LOG2_DECIM),
      .OUT_BITS   (OUT_BITS),
      .PIPE       (PIPE)
    ) u_lane (
      .clk      (CLK),
      .rst_n    (RSTb),
      .in_valid (bus.in_valid),
      .dump     (dump),
      .stb      (vld_pipe[PIPE-1:0]),
      .x        (x_l[g]),
      .y        (y_l[g])
    );
  end

  assign bus.out_valid = vld_pipe[PIPE];
  assign bus.I_out     = y_l[0];
  assign bus.Q_out     = y_l[1];
endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator: stimulus queues expected frames, a monitor checks strobes.
module tb_cic_decimator;
  localparam int BITS = 16, STAGES = 3, LOG2_DECIM = 6, OUT_BITS = 16, DECIM = 64;
`ifdef CIC_ROUND_EN
  localparam int LAT = STAGES + 2;
  localparam int ALT_LO = 0;
`else
  localparam int LAT = STAGES + 1;
  localparam int ALT_LO = -1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cic_decimator_if #(.BITS(BITS), .OUT_BITS(OUT_BITS)) bus();

  cic_decimator #(
    .BITS(BITS), .STAGES(STAGES), .LOG2_DECIM(LOG2_DECIM), .OUT_BITS(OUT_BITS)
  ) dut (
    .CLK  (clk),
    .RSTb (rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    bit chk;
    int i_lo, i_hi, q_lo, q_hi;
  } exp_t;

  exp_t sbq[$];
  int checks = 0, errors = 0;
  int acc_cnt = 0, frame = 0;
  int ei_lo, ei_hi, eq_lo, eq_hi;

  // One cycle of stimulus; the 64th accepted sample of a frame queues its expected output.
  task automatic drive(input bit v, input int i, input int q);
    exp_t e;
    @(negedge clk);
    bus.in_valid = v;
    bus.I_in     = BITS'(i);
    bus.Q_in     = BITS'(q);
    if (v) begin
      if (acc_cnt == DECIM-1) begin
        frame++;
        e.due  = cyc + LAT;
        e.chk  = (frame >= STAGES+1);
        e.i_lo = ei_lo; e.i_hi = ei_hi;
        e.q_lo = eq_lo; e.q_hi = eq_hi;
        sbq.push_back(e);
        acc_cnt = 0;
      end else begin
        acc_cnt++;
      end
    end
  endtask

  task automatic apply_reset(input int n, input bit chk);
    @(negedge clk);
    rst_n = 1'b0;
    sbq.delete();
    acc_cnt = 0;
    frame = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom);
      bus.I_in     = 16'($urandom);
      bus.Q_in     = 16'($urandom);
      if (chk) begin
        checks++;
        if (bus.out_valid !== 1'b0 || bus.I_out !== '0 || bus.Q_out !== '0) begin
          errors++;
          $display("FAIL reset_hold: out_valid=%0b I_out=%0d Q_out=%0d, required 0 0 0",
                   bus.out_valid, bus.I_out, bus.Q_out);
        end
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic run_const(input int frames, input int i, input int q, input int gap);
    ei_lo = i; ei_hi = i; eq_lo = q; eq_hi = q;
    for (int n = 0; n < frames*DECIM; n++) begin
      for (int g = 0; g < gap; g++) drive(1'b0, int'($urandom), int'($urandom));
      drive(1'b1, i, q);
    end
  endtask

  // Monitor: every strobe must match the oldest queued frame in time and value.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: out_valid=1 at cycle %0d, required no strobe", cyc);
        end else begin
          e = sbq.pop_front();
          if (cyc != e.due) begin
            errors++;
            $display("FAIL strobe_time: strobe at cycle %0d, required cycle %0d", cyc, e.due);
          end
          if (e.chk) begin
            checks++;
            if (int'(bus.I_out) < e.i_lo || int'(bus.I_out) > e.i_hi) begin
              errors++;
              $display("FAIL I_out: got %0d, required %0d..%0d", bus.I_out, e.i_lo, e.i_hi);
            end
            checks++;
            if (int'(bus.Q_out) < e.q_lo || int'(bus.Q_out) > e.q_hi) begin
              errors++;
              $display("FAIL Q_out: got %0d, required %0d..%0d", bus.Q_out, e.q_lo, e.q_hi);
            end
          end
        end
      end else if (rst_n && sbq.size() > 0 && cyc > sbq[0].due) begin
        checks++;
        errors++;
        $display("FAIL missing_strobe: none by cycle %0d, required at cycle %0d", cyc, sbq[0].due);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.in_valid = 1'b0;
    bus.I_in = '0;
    bus.Q_in = '0;

    // Reset held with toggling inputs: outputs must stay cleared.
    apply_reset(4, 1'b1);

    // DC: gain is exactly one through the trim.
    run_const(6, 1000, -1000, 0);

    // Async reset mid-frame clears outputs before the next clock edge.
    for (int n = 0; n < 20; n++) drive(1'b1, 1000, -1000);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.I_out !== '0 || bus.Q_out !== '0) begin
      errors++;
      $display("FAIL async_clear: out_valid=%0b I_out=%0d Q_out=%0d, required 0 0 0",
               bus.out_valid, bus.I_out, bus.Q_out);
    end
    apply_reset(2, 1'b0);

    // Full scale: integrators wrap internally, output must not.
    run_const(6, -32768, 32767, 0);

    // Gapped input: one accepted sample every third cycle, garbage on idle cycles.
    apply_reset(2, 1'b0);
    run_const(5, 500, -500, 2);

    // Alternating +/-1000 sits on a CIC null.
    apply_reset(2, 1'b0);
    ei_lo = ALT_LO; ei_hi = 0; eq_lo = ALT_LO; eq_hi = 0;
    for (int n = 0; n < 6*DECIM; n++)
      drive(1'b1, (n % 2) ? -1000 : 1000, (n % 2) ? 1000 : -1000);

    // Drain outstanding frames within a bounded window.
    for (int k = 0; k < 20 && sbq.size() > 0; k++) drive(1'b0, 0, 0);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d frames still pending, required 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
